// File: rtl/memoria_resp_pkg.sv
// Shared types and defaults for the memoria_resp memory responder.
package memoria_resp_pkg;

    typedef enum logic [1:0] {
        OCIOSO         = 2'd0,
        LEITURA_ESPERA = 2'd1,
        LEITURA_FIM    = 2'd2,
        ESCRITA_FIM    = 2'd3
    } estado_mem_t;

    localparam int MEM_LAT_PADRAO    = 2;
    localparam int MEM_ADDR_W_PADRAO = 8;
    localparam int MEM_DATA_W        = 32;

endpackage

// File: rtl/memoria_resp_ram_sp.sv
// ram_sp: single-port synchronous RAM, read-first, one registered read port.
module ram_sp #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
        r_rdata <= r_mem[i_addr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/memoria_resp.sv
// memoria_resp: word memory responder with fixed read latency LAT and a Pronto strobe.
// Optional misaligned-request rejection (Erro port) with MEMORIA_RESP_ALIGN_CHECK_EN.
module memoria_resp
    import memoria_resp_pkg::*;
#(
    parameter int ADDR_W = MEM_ADDR_W_PADRAO,
    parameter int LAT    = MEM_LAT_PADRAO
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Req,
    input  logic        Wr,
    input  logic [31:0] Address,
    input  logic [31:0] DataIn,
    output logic [31:0] DataOut,
    output logic        Pronto,
    output logic        Ocupado
`ifdef MEMORIA_RESP_ALIGN_CHECK_EN
    ,
    output logic        Erro
`endif
);

    localparam int CNT_W = $clog2(LAT + 1);

    generate
        if (LAT < 1) begin : g_lat_invalido
            $error("memoria_resp: LAT must be at least 1");
        end
    endgenerate

    estado_mem_t                 r_estado;
    estado_mem_t                 w_prox;
    logic [ADDR_W-1:0]           r_idx;
    logic [CNT_W-1:0]            r_cnt;
    logic [31:0]                 r_dado;
    logic [ADDR_W-1:0]           w_idx_in;
    logic [ADDR_W-1:0]           w_ram_addr;
    logic [MEM_DATA_W-1:0]       w_ram_q;
    logic                        w_desalinhado;
    logic                        w_aceita_rd;
    logic                        w_ram_we;
    logic                        w_carrega_dado;
    logic                        w_unused_addr;

    assign w_idx_in      = Address[ADDR_W+1:2];
    assign w_unused_addr = ^{Address[31:ADDR_W+2], Address[1:0]};

`ifdef MEMORIA_RESP_ALIGN_CHECK_EN
    logic r_erro;

    assign w_desalinhado = |Address[1:0];

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_erro <= 1'b0;
        end else begin
            r_erro <= (r_estado == OCIOSO) && Req && w_desalinhado;
        end
    end

    assign Erro = r_erro;
`else
    assign w_desalinhado = 1'b0;
`endif

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_estado <= OCIOSO;
        end else begin
            r_estado <= w_prox;
        end
    end

    always_comb begin
        w_prox         = r_estado;
        Pronto         = 1'b0;
        Ocupado        = 1'b1;
        w_aceita_rd    = 1'b0;
        w_ram_we       = 1'b0;
        w_carrega_dado = 1'b0;
        case (r_estado)
            OCIOSO: begin
                Ocupado = 1'b0;
                if (Req && !w_desalinhado) begin
                    if (Wr) begin
                        // A write accepted on a reset edge must not reach the array.
                        w_ram_we = !Reset;
                        w_prox   = ESCRITA_FIM;
                    end else begin
                        w_aceita_rd = 1'b1;
                        w_prox      = LEITURA_ESPERA;
                    end
                end
            end
            LEITURA_ESPERA: begin
                if (r_cnt == CNT_W'(1)) begin
                    w_carrega_dado = 1'b1;
                    w_prox         = LEITURA_FIM;
                end
            end
            LEITURA_FIM: begin
                Pronto = 1'b1;
                w_prox = OCIOSO;
            end
            ESCRITA_FIM: begin
                Pronto = 1'b1;
                w_prox = OCIOSO;
            end
            default: begin
                w_prox = OCIOSO;
            end
        endcase
    end

    // The RAM address follows the live bus only while idle, so its registered
    // output already holds the latched word from the accepting edge onwards.
    assign w_ram_addr = (r_estado == OCIOSO) ? w_idx_in : r_idx;

    always_ff @(posedge Clock) begin
        if (w_aceita_rd) begin
            r_idx <= w_idx_in;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_cnt  <= '0;
            r_dado <= '0;
        end else begin
            if (w_aceita_rd) begin
                r_cnt <= CNT_W'(LAT);
            end else if ((r_estado == LEITURA_ESPERA) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
            if (w_carrega_dado) begin
                r_dado <= w_ram_q;
            end
        end
    end

    assign DataOut = r_dado;

    ram_sp #(
        .ADDR_W (ADDR_W),
        .DATA_W (MEM_DATA_W)
    ) u_ram (
        .i_clk   (Clock),
        .i_we    (w_ram_we),
        .i_addr  (w_ram_addr),
        .i_wdata (DataIn),
        .o_rdata (w_ram_q)
    );

endmodule

// File: tb/tb_memoria_resp.sv
// Directed bench for memoria_resp: one instance at LAT=2, one at LAT=4.
module tb_memoria_resp;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        Req;
    logic        Req4;
    logic        Wr;
    logic [31:0] Address;
    logic [31:0] DataIn;
    logic [31:0] DataOut,  DataOut4;
    logic        Pronto,   Pronto4;
    logic        Ocupado,  Ocupado4;
`ifdef MEMORIA_RESP_ALIGN_CHECK_EN
    logic        Erro, Erro4;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 Clock = ~Clock;

    memoria_resp #(.ADDR_W(8), .LAT(2)) dut (
        .Clock   (Clock),
        .Reset   (Reset),
        .Req     (Req),
        .Wr      (Wr),
        .Address (Address),
        .DataIn  (DataIn),
        .DataOut (DataOut),
        .Pronto  (Pronto),
        .Ocupado (Ocupado)
`ifdef MEMORIA_RESP_ALIGN_CHECK_EN
        ,
        .Erro    (Erro)
`endif
    );

    memoria_resp #(.ADDR_W(8), .LAT(4)) dut4 (
        .Clock   (Clock),
        .Reset   (Reset),
        .Req     (Req4),
        .Wr      (Wr),
        .Address (Address),
        .DataIn  (DataIn),
        .DataOut (DataOut4),
        .Pronto  (Pronto4),
        .Ocupado (Ocupado4)
`ifdef MEMORIA_RESP_ALIGN_CHECK_EN
        ,
        .Erro    (Erro4)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic wr2(input logic [31:0] a, input logic [31:0] d);
        Req = 1'b1; Wr = 1'b1; Address = a; DataIn = d;
        tick();
        Req = 1'b0; Wr = 1'b0;
        chk("wr_pronto", {31'd0, Pronto}, 32'd1);
        tick();
    endtask

    task automatic rd2(input string tag, input logic [31:0] a, input logic [31:0] exp);
        Req = 1'b1; Wr = 1'b0; Address = a;
        tick();
        Req = 1'b0;
        tick();
        chk({tag, "_early"}, {31'd0, Pronto}, 32'd0);
        tick();
        chk({tag, "_pronto"}, {31'd0, Pronto}, 32'd1);
        chk({tag, "_data"}, DataOut, exp);
        tick();
    endtask

    initial begin
        int n_pr;
        Reset = 1'b1; Req = 1'b0; Req4 = 1'b0; Wr = 1'b0;
        Address = 32'd0; DataIn = 32'd0;
        tick();
        tick();
        Reset = 1'b0;
        chk("rst_dataout", DataOut, 32'd0);
        chk("rst_pronto", {31'd0, Pronto}, 32'd0);
        chk("rst_ocupado", {31'd0, Ocupado}, 32'd0);
        chk("rst_ocupado4", {31'd0, Ocupado4}, 32'd0);
`ifdef MEMORIA_RESP_ALIGN_CHECK_EN
        chk("rst_erro", {31'd0, Erro}, 32'd0);
`endif

        // Write then read back with LAT=2: Pronto at N+1 for write, N+3 for read.
        Req = 1'b1; Wr = 1'b1; Address = 32'h10; DataIn = 32'hDEADBEEF;
        tick();
        Req = 1'b0; Wr = 1'b0; Address = 32'h0; DataIn = 32'h0;
        chk("w1_pronto", {31'd0, Pronto}, 32'd1);
        chk("w1_ocupado", {31'd0, Ocupado}, 32'd1);
        tick();
        chk("w1_pronto_off", {31'd0, Pronto}, 32'd0);
        chk("w1_ocupado_off", {31'd0, Ocupado}, 32'd0);
        Req = 1'b1; Address = 32'h10;
        tick();
        Req = 1'b0; Address = 32'h0;
        for (int c = 1; c <= 4; c++) begin
            chk("r1_pronto", {31'd0, Pronto}, {31'd0, c == 3});
            chk("r1_ocupado", {31'd0, Ocupado}, {31'd0, c <= 3});
            if (c >= 3) chk("r1_data", DataOut, 32'hDEADBEEF);
            tick();
        end

        // LAT=4 instance: busy for 5 cycles, single Pronto at N+5.
        Req4 = 1'b1; Wr = 1'b1; Address = 32'h40; DataIn = 32'hA5A50040;
        tick();
        Req4 = 1'b0; Wr = 1'b0;
        tick();
        Req4 = 1'b1; Address = 32'h40; DataIn = 32'h0;
        tick();
        Req4 = 1'b0; Address = 32'h0;
        for (int c = 1; c <= 6; c++) begin
            chk("lat4_ocupado", {31'd0, Ocupado4}, {31'd0, c <= 5});
            chk("lat4_pronto", {31'd0, Pronto4}, {31'd0, c == 5});
            if (c >= 5) chk("lat4_data", DataOut4, 32'hA5A50040);
            tick();
        end
        chk("lat4_hold", DataOut4, 32'hA5A50040);

        // Requests during the wait states must be ignored, including a write.
        wr2(32'h20, 32'hCAFEF00D);
        Req = 1'b1; Wr = 1'b0; Address = 32'h20;
        tick();
        Address = 32'h10;
        tick();
        Wr = 1'b1; DataIn = 32'h0;
        tick();
        Req = 1'b0; Wr = 1'b0;
        n_pr = 0;
        for (int c = 0; c < 5; c++) begin
            if (Pronto) n_pr++;
            if (c == 0) chk("ign_data", DataOut, 32'hCAFEF00D);
            tick();
        end
        chk("ign_pronto_count", n_pr, 32'd1);
        rd2("ign_nowrite", 32'h10, 32'hDEADBEEF);

        // Address wrap: 0x404 and 0x004 map to the same word with ADDR_W=8.
        wr2(32'h404, 32'h12345678);
        rd2("wrap", 32'h004, 32'h12345678);

        // Reset in the second wait cycle aborts the read.
        Req = 1'b1; Address = 32'h10;
        tick();
        Req = 1'b0;
        tick();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        chk("mid_rst_pronto", {31'd0, Pronto}, 32'd0);
        chk("mid_rst_data", DataOut, 32'd0);
        chk("mid_rst_ocupado", {31'd0, Ocupado}, 32'd0);
        tick();
        chk("mid_rst_late_pronto", {31'd0, Pronto}, 32'd0);
        rd2("post_rst", 32'h20, 32'hCAFEF00D);

        // A write accepted on a reset edge is dropped.
        Req = 1'b1; Wr = 1'b1; Address = 32'h20; DataIn = 32'h11111111; Reset = 1'b1;
        tick();
        Req = 1'b0; Wr = 1'b0; Reset = 1'b0;
        chk("rst_wr_pronto", {31'd0, Pronto}, 32'd0);
        chk("rst_wr_ocupado", {31'd0, Ocupado}, 32'd0);
        rd2("rst_wr_nocommit", 32'h20, 32'hCAFEF00D);

`ifdef MEMORIA_RESP_ALIGN_CHECK_EN
        Req = 1'b1; Wr = 1'b1; Address = 32'h13; DataIn = 32'hFFFFFFFF;
        tick();
        Req = 1'b0; Wr = 1'b0;
        chk("align_erro", {31'd0, Erro}, 32'd1);
        chk("align_pronto", {31'd0, Pronto}, 32'd0);
        chk("align_ocupado", {31'd0, Ocupado}, 32'd0);
        tick();
        chk("align_erro_off", {31'd0, Erro}, 32'd0);
        chk("align_pronto_off", {31'd0, Pronto}, 32'd0);
        rd2("align_unchanged", 32'h10, 32'hDEADBEEF);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
